instr_prefetch_queue: RTL

// - Parametrised instruction fetch front-end for the ARM-subset processor.
// - Generates the PC, issues word fetches to instruction memory, and buffers returned

---
 rtl/instr_prefetch_queue_if.sv | 32 +++
 rtl/instr_prefetch_queue.sv | 121 ++++++++++++
 2 files changed

// File: rtl/instr_prefetch_queue_if.sv
// Fetch-side bus bundle for instr_prefetch_queue: instruction memory port,
// branch redirect, and the decode-side valid/ready handshake.
// master = the prefetch queue, slave = memory/execute/decode environment.
interface instr_prefetch_queue_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_valid;
  logic [INSTR_W-1:0] imem_rdata;
  logic               br_taken;
  logic [ADDR_W-1:0]  br_target;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;
  logic               instr_ready;
  logic [CW-1:0]      fifo_count;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc, fifo_count,
    input  imem_valid, imem_rdata, br_taken, br_target, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, fifo_count,
    output imem_valid, imem_rdata, br_taken, br_target, instr_ready
  );
endinterface

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: generates the PC, issues one word fetch at a
// time, buffers returned words with their addresses in a DEPTH-entry FIFO and
// hands them to decode. A taken branch flushes the FIFO and redirects the PC;
// a fetch in flight at redirect time is marked stale and dropped on return.
// Optional build macro: IPQ_PERF_EN adds saturating perf_fetches/perf_flushes.
module instr_prefetch_queue #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 4,
  parameter int RST_PC  = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  instr_prefetch_queue_if.master bus
`ifdef IPQ_PERF_EN
  ,
  output logic [15:0]            perf_fetches,
  output logic [15:0]            perf_flushes
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = $clog2(DEPTH);

  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  r_req_addr;
  logic               r_outst;
  logic               r_stale;
  logic [CW-1:0]      r_count;
  logic [PW-1:0]      r_wptr;
  logic [PW-1:0]      r_rptr;
  logic [INSTR_W-1:0] r_mem_instr [DEPTH];
  logic [ADDR_W-1:0]  r_mem_pc    [DEPTH];

  logic              w_empty;
  logic              w_issue;
  logic              w_resp;
  logic              w_push;
  logic              w_pop;
  logic [ADDR_W-1:0] w_tgt;

  assign w_empty = (r_count == '0);
  // The outstanding fetch reserves a slot, so a push can never overflow.
  assign w_issue = ~rst & ~r_outst & ~bus.br_taken &
                   ((r_count + CW'(r_outst)) < CW'(DEPTH));
  assign w_resp  = bus.imem_valid & r_outst;
  assign w_push  = w_resp & ~r_stale & ~bus.br_taken;
  assign w_pop   = ~w_empty & bus.instr_ready;
  assign w_tgt   = bus.br_target & ~ADDR_W'(3);

  assign bus.imem_req    = w_issue;
  assign bus.imem_addr   = r_pc;
  assign bus.instr_valid = ~w_empty;
  assign bus.instr       = w_empty ? '0 : r_mem_instr[r_rptr];
  assign bus.instr_pc    = w_empty ? '0 : r_mem_pc[r_rptr];
  assign bus.fifo_count  = r_count;

  // PC, fetch tracking and FIFO pointers; redirect overrides everything else.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc       <= ADDR_W'(RST_PC);
      r_req_addr <= '0;
      r_outst    <= 1'b0;
      r_stale    <= 1'b0;
      r_count    <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
    end else if (bus.br_taken) begin
      r_pc    <= w_tgt;
      r_count <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      // A fetch still in flight must be dropped; one returning now is discarded here.
      r_outst <= r_outst & ~bus.imem_valid;
      r_stale <= r_outst & ~bus.imem_valid;
    end else begin
      if (w_issue) begin
        r_pc       <= r_pc + ADDR_W'(4);
        r_req_addr <= r_pc;
        r_outst    <= 1'b1;
      end
      if (w_resp) begin
        r_outst <= 1'b0;
        r_stale <= 1'b0;
      end
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage; contents are only visible through the occupancy gate.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_instr[r_wptr] <= bus.imem_rdata;
      r_mem_pc[r_wptr]    <= r_req_addr;
    end
  end

`ifdef IPQ_PERF_EN
  logic [15:0] r_perf_fetches;
  logic [15:0] r_perf_flushes;

  assign perf_fetches = r_perf_fetches;
  assign perf_flushes = r_perf_flushes;

  // Saturating event counters: delivered words and redirects.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_fetches <= '0;
      r_perf_flushes <= '0;
    end else begin
      if (w_push && r_perf_fetches != 16'hFFFF)       r_perf_fetches <= r_perf_fetches + 16'd1;
      if (bus.br_taken && r_perf_flushes != 16'hFFFF) r_perf_flushes <= r_perf_flushes + 16'd1;
    end
  end
`endif
endmodule
